// File: rtl/sc_mat_pkg.sv
// Shared types and constants for the complex matrix-add Avalon-MM host driver.
// Sizes, byte-enable patterns, FSM states and the matrix word-count helper.
package sc_mat_pkg;

    localparam int AVMM_ADDR_W = 23;
    localparam int AVMM_DATA_W = 64;

    localparam logic [7:0] BE_LO  = 8'h0F;
    localparam logic [7:0] BE_HI  = 8'hF0;
    localparam logic [7:0] BE_ALL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        TRIG,
        BUSY,
        RD,
        DONE
    } state_t;

    // Real and imaginary 64-bit words of an n x n complex matrix.
    function automatic int word_count(input int n);
        return 2 * n * n;
    endfunction

endpackage

// File: rtl/sc_avmm_watchdog.sv
// Loadable down-counter that pulses expire on the last counted cycle.
// Bounds the trigger acknowledge and busy window of the accelerator.
module sc_avmm_watchdog #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/sc_mat_add_avmm_master.sv
// Avalon-MM host driver: writes A and B as half-word beats, triggers the
// matrix-add slave, waits out its busy window and reads C back.
module sc_mat_add_avmm_master
    import sc_mat_pkg::*;
#(
    parameter int mat_num_row    = 2,
    parameter int timeout_cycles = 1024
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [64*word_count(mat_num_row)-1:0] mat_a,
    input  logic [64*word_count(mat_num_row)-1:0] mat_b,
    output logic [64*word_count(mat_num_row)-1:0] mat_c,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  timeout_err,
    output logic [AVMM_ADDR_W-1:0]                address,
    output logic [AVMM_DATA_W-1:0]                writedata,
    output logic                                  write,
    output logic                                  read,
    output logic [7:0]                            byteenable,
    input  logic [AVMM_DATA_W-1:0]                readdata,
    input  logic                                  waitrequest
);

    localparam int W  = word_count(mat_num_row);
    localparam int KW = $clog2(2 * W);
    localparam int RW = $clog2(W);
    localparam int TW = $clog2(timeout_cycles + 1);
    localparam logic [AVMM_ADDR_W-1:0] TRIG_ADDR = AVMM_ADDR_W'(2 * W);

    state_t                 state, state_nxt;
    logic [KW-1:0]          k, k_nxt;
    logic [AVMM_DATA_W-1:0] ops [2*W];
    logic [AVMM_DATA_W-1:0] c_q [W];
    logic                   wd_load, wd_en, wd_clr, wd_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Operand words 0..W-1 are A, W..2W-1 are B, matching the slave map.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 2 * W; j++) ops[j] <= '0;
        end else if (state == IDLE && start) begin
            for (int j = 0; j < W; j++) begin
                ops[j]     <= mat_a[64*j +: 64];
                ops[W + j] <= mat_b[64*j +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < W; j++) c_q[j] <= '0;
        end else if (state == RD) begin
            c_q[k[RW-1:0]] <= readdata;
        end
    end

    for (genvar j = 0; j < W; j++) begin : g_c
        assign mat_c[64*j +: 64] = c_q[j];
    end

    assign wd_en  = (state == TRIG) || (state == BUSY);
    assign wd_clr = (state == IDLE);

    sc_avmm_watchdog #(
        .CNT_W(TW)
    ) u_wd (
        .clk      (clk),
        .reset    (reset),
        .clr      (wd_clr),
        .load     (wd_load),
        .en       (wd_en),
        .load_val (TW'(timeout_cycles)),
        .expire   (wd_expire)
    );

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        address     = '0;
        writedata   = '0;
        write       = 1'b0;
        read        = 1'b0;
        byteenable  = '0;
        busy        = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        wd_load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WR_LO;
                    k_nxt     = '0;
                end
            end
            WR_LO: begin
                busy       = 1'b1;
                address    = AVMM_ADDR_W'(k);
                writedata  = ops[k];
                byteenable = BE_LO;
                write      = 1'b1;
                if (!waitrequest) state_nxt = WR_HI;
            end
            WR_HI: begin
                busy       = 1'b1;
                address    = AVMM_ADDR_W'(k);
                writedata  = ops[k];
                byteenable = BE_HI;
                write      = 1'b1;
                if (!waitrequest) begin
                    if (k == KW'(2 * W - 1)) begin
                        state_nxt = TRIG;
                        k_nxt     = '0;
                        wd_load   = 1'b1;
                    end else begin
                        state_nxt = WR_LO;
                        k_nxt     = k + KW'(1);
                    end
                end
            end
            TRIG: begin
                busy    = 1'b1;
                address = TRIG_ADDR;
                // The slave registers its stall, so the ack lags by a cycle.
                if (waitrequest) begin
                    state_nxt = BUSY;
                    wd_load   = 1'b1;
                end else if (wd_expire) begin
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (!waitrequest) begin
                    state_nxt = RD;
                    k_nxt     = '0;
                end else if (wd_expire) begin
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RD: begin
                busy       = 1'b1;
                address    = AVMM_ADDR_W'(k);
                read       = 1'b1;
                byteenable = BE_ALL;
                if (k == KW'(W - 1)) begin
                    state_nxt = DONE;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sc_mat_add_avmm_master.sv
// Directed bench for the matrix-add Avalon-MM host driver with a behavioural
// slave: write beats, stalls, busy window, reset abort, start-ignore, timeout.
`timescale 1ns/1ps
module tb_sc_mat_add_avmm_master;

    localparam int N  = 2;
    localparam int W  = 2 * N * N;
    localparam int MW = 64 * W;
    localparam int AW = $clog2(2 * W);
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic [MW-1:0] mat_a, mat_b, mat_c;
    logic          busy, done, timeout_err;
    logic [22:0]   address;
    logic [63:0]   writedata;
    logic          write, read;
    logic [7:0]    byteenable;
    logic [63:0]   readdata;
    logic          waitrequest;

    logic          t_start;
    logic [MW-1:0] t_mat_c;
    logic          t_busy, t_done, t_timeout_err;
    logic [22:0]   t_address;
    logic [63:0]   t_writedata;
    logic          t_write, t_read;
    logic [7:0]    t_byteenable;
    logic [63:0]   t_readdata    = 64'h0;
    logic          t_waitrequest = 1'b0;

    sc_mat_add_avmm_master #(.mat_num_row(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mat_a       (mat_a),
        .mat_b       (mat_b),
        .mat_c       (mat_c),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .address     (address),
        .writedata   (writedata),
        .write       (write),
        .read        (read),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    sc_mat_add_avmm_master #(.mat_num_row(N), .timeout_cycles(16)) dut_to (
        .clk         (clk),
        .reset       (reset),
        .start       (t_start),
        .mat_a       (mat_a),
        .mat_b       (mat_b),
        .mat_c       (t_mat_c),
        .busy        (t_busy),
        .done        (t_done),
        .timeout_err (t_timeout_err),
        .address     (t_address),
        .writedata   (t_writedata),
        .write       (t_write),
        .read        (t_read),
        .byteenable  (t_byteenable),
        .readdata    (t_readdata),
        .waitrequest (t_waitrequest)
    );

    // Behavioural slave: half-word writes, registered busy after trigger.
    logic [63:0] mem  [2*W];
    logic [63:0] cmem [W];
    int          stall_beat, busy_len;
    int          beat_cnt, stall_seen, busy_left;
    logic        busy_wait, wr_stall, sl_clr;

    assign wr_stall    = write && (beat_cnt == stall_beat) && (stall_seen < 3);
    assign waitrequest = wr_stall || busy_wait;
    assign readdata    = read ? cmem[address[CW-1:0]] : 64'h0;

    always @(posedge clk) begin
        if (reset || sl_clr) begin
            beat_cnt   <= 0;
            stall_seen <= 0;
            busy_wait  <= 1'b0;
            busy_left  <= 0;
        end else begin
            if (wr_stall) begin
                stall_seen <= stall_seen + 1;
            end else if (write) begin
                beat_cnt <= beat_cnt + 1;
                if (byteenable == 8'h0F)
                    mem[address[AW-1:0]][31:0] <= writedata[31:0];
                else
                    mem[address[AW-1:0]][63:32] <= writedata[63:32];
            end
            if (busy_wait) begin
                if (busy_left <= 1) busy_wait <= 1'b0;
                busy_left <= busy_left - 1;
            end else if (address == 23'(2 * W) && !write && !read) begin
                busy_wait <= 1'b1;
                busy_left <= busy_len;
                for (int j = 0; j < W; j++) cmem[j] <= mem[j] + mem[W + j];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_address"}, 64'(address), 64'd0);
        check({tag, "_writedata"}, writedata, 64'd0);
        check({tag, "_be"}, 64'(byteenable), 64'd0);
        check({tag, "_write"}, 64'(write), 64'd0);
        check({tag, "_read"}, 64'(read), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_terr"}, 64'(timeout_err), 64'd0);
        for (int j = 0; j < W; j++)
            check({tag, "_mat_c"}, mat_c[64*j +: 64], 64'd0);
    endtask

    // mode 0: plain run, 1: reset at beat 9, 2: extra start pulse during RD
    task automatic run_txn(input string tag, input logic [63:0] ab,
                           input logic [63:0] bb, input int bl,
                           input int sb, input int mode);
        int n, beat, rd, trig, zero, stl, dn, lat, to, exp_lat;
        logic [63:0] ew;
        n = 0; beat = 0; rd = 0; trig = 0; zero = 0;
        stl = 0; dn = 0; lat = -1; to = 0;
        busy_len   = bl;
        stall_beat = sb;
        for (int j = 0; j < W; j++) begin
            mat_a[64*j +: 64] = ab + 64'(j);
            mat_b[64*j +: 64] = bb + 64'(j);
        end
        sl_clr = 1'b1;
        @(negedge clk);
        sl_clr = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        n = 1;
        while (lat < 0 && n < 600) begin
            start = 1'b0;
            if (write) begin
                ew = (beat / 2 < W) ? ab + 64'(beat / 2) : bb + 64'(beat / 2 - W);
                check({tag, "_wr_addr"}, 64'(address), 64'(beat / 2));
                check({tag, "_wr_be"}, 64'(byteenable),
                      (beat % 2 == 1) ? 64'hF0 : 64'h0F);
                check({tag, "_wr_data"}, writedata, ew);
                check({tag, "_wr_rd_excl"}, 64'(read), 64'd0);
                if (mode == 1 && beat == 9) begin
                    reset = 1'b1;
                    @(negedge clk);
                    check_reset_vals({tag, "_mid"});
                    reset = 1'b0;
                    @(negedge clk);
                    return;
                end
                if (waitrequest) stl++;
                else beat++;
            end
            if (read) begin
                check({tag, "_rd_addr"}, 64'(address), 64'(rd));
                check({tag, "_rd_be"}, 64'(byteenable), 64'hFF);
                if (mode == 2 && rd == 0) begin
                    start = 1'b1;
                    mat_a = ~mat_a;
                    mat_b = ~mat_b;
                end
                rd++;
            end
            if (busy && !write && !read) begin
                if (address == 23'(2 * W)) trig++;
                else if (address == 23'd0) zero++;
            end
            if (timeout_err) to++;
            if (done) begin
                lat = n;
                check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (lat < 0) begin
            check({tag, "_done_seen"}, 64'd0, 64'd1);
            return;
        end
        exp_lat = 4 * W + 2 + bl + W + 1 + ((sb >= 0) ? 3 : 0);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_beats"}, 64'(beat), 64'(4 * W));
        check({tag, "_stall_cyc"}, 64'(stl), (sb >= 0) ? 64'd3 : 64'd0);
        check({tag, "_reads"}, 64'(rd), 64'(W));
        check({tag, "_trig_cyc"}, 64'(trig), 64'd2);
        check({tag, "_busy_addr0"}, 64'(zero), 64'(bl));
        check({tag, "_no_terr"}, 64'(to), 64'd0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b0;
            @(negedge clk);
            if (done) dn++;
        end
        check({tag, "_extra_done"}, 64'(dn), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        for (int j = 0; j < W; j++)
            check({tag, "_mat_c"}, mat_c[64*j +: 64], ab + bb + 64'(2 * j));
    endtask

    task automatic run_timeout();
        int n, trig, dn;
        logic hit;
        n = 0; trig = 0; dn = 0; hit = 1'b0;
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        n = 1;
        while (!hit && n < 300) begin
            if (t_address == 23'(2 * W)) trig++;
            if (t_done) dn++;
            if (t_timeout_err) hit = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("to_pulse", 64'(hit), 64'd1);
        check("to_cycle", 64'(n), 64'(4 * W + 16));
        check("to_trig_cyc", 64'(trig), 64'd16);
        check("to_write_low", 64'(t_write), 64'd0);
        @(negedge clk);
        check("to_busy_after", 64'(t_busy), 64'd0);
        check("to_pulse_width", 64'(t_timeout_err), 64'd0);
        check("to_addr_after", 64'(t_address), 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (t_done) dn++;
            @(negedge clk);
        end
        check("to_no_done", 64'(dn), 64'd0);
        for (int j = 0; j < W; j++)
            check("to_mat_c", t_mat_c[64*j +: 64], 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        t_start    = 1'b0;
        sl_clr     = 1'b0;
        busy_len   = 4;
        stall_beat = -1;
        mat_a      = '0;
        mat_b      = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        run_txn("t1_basic", 64'h1000, 64'h2000, 4, -1, 0);
        run_txn("t2_stall", 64'h1000, 64'h2000, 4, 5, 0);
        run_txn("t3_busy40", 64'h1000, 64'h2000, 40, -1, 0);
        run_txn("t4_rst", 64'h1000, 64'h2000, 4, -1, 1);
        run_txn("t4_after", 64'h5000, 64'h0100, 4, -1, 0);
        run_txn("t5_start_rd", 64'h7000, 64'h0200, 6, -1, 2);
        run_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
